// File: rtl/elevator_car_model_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_car_model_if
// Description : Command/status byte pair between elevator interface and car.
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_car_model_if;
  logic [7:0] data_from_ctrl;
  logic [7:0] data_to_ctrl;

  modport master (output data_from_ctrl, input data_to_ctrl);
  modport slave  (input data_from_ctrl, output data_to_ctrl);
endinterface
`default_nettype wire

// File: rtl/elevator_car_model.sv
`default_nettype none
// ============================================================================
// Module      : elevator_car_model
// Description : Car, motor and door model; one floor per command, counter-timed.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_car_model #(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  elevator_car_model_if.slave    bus
);

  localparam int c_CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_TRAVEL_LOAD = c_CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DOOR_LOAD   = c_CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_floor, w_floor_nxt;
  logic [c_CNT_W-1:0]   r_count, w_count_nxt;
  logic                 r_dir, w_dir_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_fault, w_fault_nxt;
  logic [7:0]           r_status;
  logic [7:0]           w_status_nxt;

  logic w_dir_req, w_move_req, w_door_req, w_move_legal;
  logic w_unused_cmd;

  assign w_dir_req    = bus.data_from_ctrl[0];
  assign w_move_req   = bus.data_from_ctrl[1];
  assign w_door_req   = bus.data_from_ctrl[2];
  assign w_unused_cmd = ^bus.data_from_ctrl[7:3];
  assign w_move_legal = w_dir_req ? (r_floor != 2'd3) : (r_floor != 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_done_nxt  = r_done;
    w_fault_nxt = r_fault;
    case (r_state)
      ST_IDLE: begin
        // Move outranks door when both are requested.
        if (w_move_req) begin
          if (w_move_legal) begin
            w_dir_nxt   = w_dir_req;
            w_fault_nxt = 1'b0;
            w_count_nxt = c_TRAVEL_LOAD;
            w_state_nxt = ST_MOVING;
          end else begin
            w_fault_nxt = 1'b1;
          end
        end else if (w_door_req) begin
          w_fault_nxt = 1'b0;
          w_count_nxt = c_DOOR_LOAD;
          w_state_nxt = ST_DOOR_OPEN;
        end
      end
      ST_MOVING: begin
        if (r_count == '0) begin
          w_floor_nxt = r_dir ? (r_floor + 2'd1) : (r_floor - 2'd1);
          w_done_nxt  = ~r_done;
          w_state_nxt = ST_IDLE;
        end else begin
          w_count_nxt = r_count - c_CNT_W'(1);
        end
      end
      ST_DOOR_OPEN: begin
        if (r_count == '0) begin
          w_done_nxt  = ~r_done;
          w_state_nxt = ST_IDLE;
        end else begin
          w_count_nxt = r_count - c_CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status mirrors the post-edge state so software sees it one cycle sooner.
  assign w_status_nxt = {w_fault_nxt,
                         w_done_nxt,
                         (w_floor_nxt == 2'd0),
                         (w_floor_nxt == 2'd3),
                         (w_state_nxt == ST_DOOR_OPEN),
                         (w_state_nxt == ST_MOVING),
                         w_floor_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_floor  <= 2'd0;
      r_count  <= '0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
      r_status <= 8'h20;
    end else begin
      r_state  <= w_state_nxt;
      r_floor  <= w_floor_nxt;
      r_count  <= w_count_nxt;
      r_dir    <= w_dir_nxt;
      r_done   <= w_done_nxt;
      r_fault  <= w_fault_nxt;
      r_status <= w_status_nxt;
    end
  end

  assign bus.data_to_ctrl = r_status;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_car_model
// Description : Directed vector table plus door/reset sequences for the car model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_car_model;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  elevator_car_model_if bus_if ();

  elevator_car_model #(
    .TRAVEL_CYCLES (16),
    .DOOR_CYCLES   (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    int         cycles;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: status got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    // Reset idle, climb 0->3, overshoot, descend 3->0, down at bottom.
    vecs[0]  = '{8'h00,  5, 8'h20};
    vecs[1]  = '{8'h03,  1, 8'h24};
    vecs[2]  = '{8'h00, 14, 8'h24};
    vecs[3]  = '{8'h00,  1, 8'h24};
    vecs[4]  = '{8'h00,  1, 8'h41};
    vecs[5]  = '{8'h03,  1, 8'h45};
    vecs[6]  = '{8'h00, 15, 8'h45};
    vecs[7]  = '{8'h00,  1, 8'h02};
    vecs[8]  = '{8'h03,  1, 8'h06};
    vecs[9]  = '{8'h00, 15, 8'h06};
    vecs[10] = '{8'h00,  1, 8'h53};
    vecs[11] = '{8'h03,  1, 8'hD3};
    vecs[12] = '{8'h00,  3, 8'hD3};
    vecs[13] = '{8'h02,  1, 8'h57};
    vecs[14] = '{8'h00, 15, 8'h57};
    vecs[15] = '{8'h00,  1, 8'h02};
    vecs[16] = '{8'h02,  1, 8'h06};
    vecs[17] = '{8'h00, 15, 8'h06};
    vecs[18] = '{8'h00,  1, 8'h41};
    vecs[19] = '{8'h02,  1, 8'h45};
    vecs[20] = '{8'h00, 15, 8'h45};
    vecs[21] = '{8'h00,  1, 8'h20};
    vecs[22] = '{8'h02,  1, 8'hA0};
    vecs[23] = '{8'h00,  2, 8'hA0};

    bus_if.data_from_ctrl = 8'h00;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", bus_if.data_to_ctrl, 8'h20);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      bus_if.data_from_ctrl = vecs[i].cmd;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d", i), bus_if.data_to_ctrl, vecs[i].exp);
    end

    // Door open with a move request held throughout the dwell.
    bus_if.data_from_ctrl = 8'h04;
    tick();
    check("door_open", bus_if.data_to_ctrl, 8'h28);
    bus_if.data_from_ctrl = 8'h03;
    for (int i = 0; i < 31; i++) begin
      tick();
      check($sformatf("door_hold%0d", i), bus_if.data_to_ctrl, 8'h28);
    end
    tick();
    check("door_close", bus_if.data_to_ctrl, 8'h60);
    tick();
    check("move_after_door", bus_if.data_to_ctrl, 8'h64);
    bus_if.data_from_ctrl = 8'h00;
    repeat (15) tick();
    check("move_after_door_travel", bus_if.data_to_ctrl, 8'h64);
    tick();
    check("move_after_door_done", bus_if.data_to_ctrl, 8'h01);

    // Both requests: move wins; then reset part-way through travel.
    bus_if.data_from_ctrl = 8'h07;
    tick();
    check("both_req_move", bus_if.data_to_ctrl, 8'h05);
    bus_if.data_from_ctrl = 8'h00;
    repeat (7) tick();
    check("pre_reset_moving", bus_if.data_to_ctrl, 8'h05);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_move", bus_if.data_to_ctrl, 8'h20);
    tick();
    check("reset_held", bus_if.data_to_ctrl, 8'h20);
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_reset_idle", bus_if.data_to_ctrl, 8'h20);
    bus_if.data_from_ctrl = 8'h03;
    tick();
    check("post_reset_move", bus_if.data_to_ctrl, 8'h24);
    bus_if.data_from_ctrl = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
